// File: rtl/conv_tile_sched_if.sv
// Load-stream control bundle between the layer scheduler
// and control_conv: proc enables plus observed handshakes.
interface conv_tile_sched_if;
  logic procin;
  logic invalid;
  logic inready;
  logic inlast;
  logic prockrnl;
  logic krnlvalid;
  logic krnlready;
  logic krnlast;
  logic procindx;
  logic indxvalid;
  logic indxready;
  logic indxlast;
  logic readynext;

  modport master (
    output procin, prockrnl, procindx,
    input  invalid, inready, inlast,
    input  krnlvalid, krnlready, krnlast,
    input  indxvalid, indxready, indxlast,
    input  readynext
  );

  modport slave (
    input  procin, prockrnl, procindx,
    output invalid, inready, inlast,
    output krnlvalid, krnlready, krnlast,
    output indxvalid, indxready, indxlast,
    output readynext
  );
endinterface

// File: rtl/conv_tile_sched.sv
// Layer scheduler: walks kernel-group x tile loop, sequencing
// input / kernel / index loads; kernel+index loaded once per group.
module conv_tile_sched #(
  parameter int TW = 8,
  parameter int GW = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [TW-1:0]       cfg_ntile,
  input  logic [GW-1:0]       cfg_nkgrp,
  conv_tile_sched_if.master   ld,
  output logic                krnl_reuse,
  output logic [TW-1:0]       tile_idx,
  output logic [GW-1:0]       kgrp_idx,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_IN,
    S_LD_KRNL,
    S_LD_INDX,
    S_WAIT_NEXT,
    S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tile_q, tile_d;
  logic [GW-1:0] kgrp_q, kgrp_d;
  logic [TW-1:0] ntile_q, ntile_d;
  logic [GW-1:0] nkgrp_q, nkgrp_d;
  logic          procin_q, procin_d;
  logic          prockrnl_q, prockrnl_d;
  logic          procindx_q, procindx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          reuse_q, reuse_d;

  logic in_last;
  logic krnl_last;
  logic indx_last;
  logic cfg_ok;
  logic tile_end;
  logic kgrp_end;

  assign in_last   = ld.invalid & ld.inready & ld.inlast;
  assign krnl_last = ld.krnlvalid & ld.krnlready & ld.krnlast;
  assign indx_last = ld.indxvalid & ld.indxready & ld.indxlast;
  assign cfg_ok    = (cfg_ntile != '0) && (cfg_nkgrp != '0);
  assign tile_end  = (tile_q == ntile_q - TW'(1));
  assign kgrp_end  = (kgrp_q == nkgrp_q - GW'(1));

  // State, loop indices, latched cfg and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tile_q     <= '0;
      kgrp_q     <= '0;
      ntile_q    <= '0;
      nkgrp_q    <= '0;
      procin_q   <= 1'b0;
      prockrnl_q <= 1'b0;
      procindx_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      reuse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tile_q     <= tile_d;
      kgrp_q     <= kgrp_d;
      ntile_q    <= ntile_d;
      nkgrp_q    <= nkgrp_d;
      procin_q   <= procin_d;
      prockrnl_q <= prockrnl_d;
      procindx_q <= procindx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      reuse_q    <= reuse_d;
    end
  end

  // Next state and loop advance; abort overrides everything when busy
  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    kgrp_d  = kgrp_q;
    ntile_d = ntile_q;
    nkgrp_d = nkgrp_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && cfg_ok) begin
            ntile_d = cfg_ntile;
            nkgrp_d = cfg_nkgrp;
            tile_d  = '0;
            kgrp_d  = '0;
            state_d = S_LD_IN;
          end else if (start) begin
            state_d = S_FIN;
          end
        end
        S_LD_IN: begin
          if (in_last) begin
            state_d = (tile_q == '0) ? S_LD_KRNL : S_WAIT_NEXT;
          end
        end
        S_LD_KRNL: begin
          if (krnl_last) state_d = S_LD_INDX;
        end
        S_LD_INDX: begin
          if (indx_last) state_d = S_WAIT_NEXT;
        end
        S_WAIT_NEXT: begin
          if (ld.readynext) begin
            if (!tile_end) begin
              tile_d  = tile_q + TW'(1);
              state_d = S_LD_IN;
            end else if (!kgrp_end) begin
              tile_d  = '0;
              kgrp_d  = kgrp_q + GW'(1);
              state_d = S_LD_IN;
            end else begin
              state_d = S_FIN;
            end
          end
        end
        S_FIN: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from next state so they line up with the state
  always_comb begin
    procin_d   = 1'b0;
    prockrnl_d = 1'b0;
    procindx_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = (state_d != S_IDLE);
    reuse_d    = (tile_d != '0);
    unique case (1'b1)
      (state_d == S_LD_IN):   procin_d   = 1'b1;
      (state_d == S_LD_KRNL): prockrnl_d = 1'b1;
      (state_d == S_LD_INDX): procindx_d = 1'b1;
      (state_d == S_FIN):     done_d     = 1'b1;
      default: ;
    endcase
  end

  assign ld.procin   = procin_q;
  assign ld.prockrnl = prockrnl_q;
  assign ld.procindx = procindx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign krnl_reuse  = reuse_q;
  assign tile_idx    = tile_q;
  assign kgrp_idx    = kgrp_q;

endmodule
